dual_issue_queue: RTL and testbench

//  12-entry issue queue feeding the dual-issue select stage. Holds µops until the source operand tag is ready.

---
 rtl/dual_issue_queue.sv | 157 +++++++++++++++
 tb/tb_dual_issue_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_queue.sv
// 12-entry wakeup/select issue queue feeding two valid/ready issue pipes.
// Optional synchronous flush input enabled by DUAL_ISSUE_QUEUE_FLUSH_EN.
module dual_issue_queue #(
  parameter int REQ_N  = 12,
  parameter int OUT_N  = $clog2(REQ_N),
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
`ifdef DUAL_ISSUE_QUEUE_FLUSH_EN
  input  logic              i_flush,
`endif
  input  logic              i_alloc_valid,
  output logic              o_alloc_ready,
  input  logic [DATA_W-1:0] i_alloc_data,
  input  logic [TAG_W-1:0]  i_alloc_tag,
  input  logic              i_alloc_rdy,
  input  logic              i_wake_valid,
  input  logic [TAG_W-1:0]  i_wake_tag,
  output logic              o_iss1_valid,
  output logic [DATA_W-1:0] o_iss1_data,
  output logic [OUT_N-1:0]  o_iss1_idx,
  input  logic              i_iss1_ready,
  output logic              o_iss2_valid,
  output logic [DATA_W-1:0] o_iss2_data,
  output logic [OUT_N-1:0]  o_iss2_idx,
  input  logic              i_iss2_ready,
  output logic [OUT_N:0]    o_count
);

  localparam int CW = OUT_N + 1;

  logic [REQ_N-1:0]  valid_q;
  logic [REQ_N-1:0]  rdy_q;
  logic [REQ_N-1:0]  valid_d;
  logic [REQ_N-1:0]  rdy_d;
  logic [TAG_W-1:0]  tag_q [REQ_N];
  logic [DATA_W-1:0] data_q [REQ_N];
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;

  logic [REQ_N-1:0]  req;
  logic [REQ_N-1:0]  req2;
  logic [REQ_N-1:0]  p1_oh;
  logic [REQ_N-1:0]  p2_oh;
  logic [REQ_N-1:0]  free_oh;
  logic [REQ_N-1:0]  wr_oh;
  logic [REQ_N-1:0]  clr_oh;
  logic [REQ_N-1:0]  wake_hit;
  logic              flush;
  logic              alloc_fire;
  logic              iss1_fire;
  logic              iss2_fire;
  logic              alloc_wake;

`ifdef DUAL_ISSUE_QUEUE_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  function automatic logic [OUT_N-1:0] enc(
    input logic [REQ_N-1:0] oh
  );
    enc = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (oh[i]) enc = enc | OUT_N'(i);
    end
  endfunction

  // x & -x isolates the lowest set bit; ~v & (v+1) the lowest clear bit
  assign req     = valid_q & rdy_q;
  assign p1_oh   = req & (~req + REQ_N'(1));
  assign req2    = req & ~p1_oh;
  assign p2_oh   = req2 & (~req2 + REQ_N'(1));
  assign free_oh = ~valid_q & (valid_q + REQ_N'(1));

  assign o_alloc_ready = ~&valid_q & ~flush;
  assign o_iss1_valid  = |req;
  assign o_iss2_valid  = |req2;
  assign o_iss1_idx    = enc(p1_oh);
  assign o_iss2_idx    = enc(p2_oh);
  assign o_count       = count_q;

  assign alloc_fire = i_alloc_valid & o_alloc_ready;
  assign iss1_fire  = o_iss1_valid & i_iss1_ready;
  assign iss2_fire  = o_iss2_valid & i_iss2_ready;
  assign alloc_wake = i_wake_valid & (i_alloc_tag == i_wake_tag);

  assign clr_oh = ({REQ_N{iss1_fire}} & p1_oh)
                | ({REQ_N{iss2_fire}} & p2_oh);
  assign wr_oh  = {REQ_N{alloc_fire}} & free_oh;

  always_comb begin
    o_iss1_data = '0;
    o_iss2_data = '0;
    wake_hit    = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (p1_oh[i]) o_iss1_data = o_iss1_data | data_q[i];
      if (p2_oh[i]) o_iss2_data = o_iss2_data | data_q[i];
      wake_hit[i] = i_wake_valid & (tag_q[i] == i_wake_tag);
    end
  end

  // Written slots are free and cleared slots are occupied: never both
  always_comb begin
    valid_d = (valid_q & ~clr_oh) | wr_oh;
    rdy_d   = '0;
    for (int i = 0; i < REQ_N; i++) begin
      unique case (1'b1)
        wr_oh[i]:  rdy_d[i] = i_alloc_rdy | alloc_wake;
        clr_oh[i]: rdy_d[i] = 1'b0;
        default:   rdy_d[i] = rdy_q[i]
                            | (valid_q[i] & wake_hit[i]);
      endcase
    end
    count_d = count_q
            + CW'(alloc_fire)
            - CW'(iss1_fire)
            - CW'(iss2_fire);
    if (flush) begin
      valid_d = '0;
      rdy_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      rdy_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REQ_N; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_N; i++) begin
        if (wr_oh[i]) begin
          tag_q[i]  <= i_alloc_tag;
          data_q[i] <= i_alloc_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: slot-array model checked each cycle,
// plus literal expectations for the listed scenarios.
module tb_dual_issue_queue;

  localparam int N  = 12;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_rdy = 1'b0;
  logic [DW-1:0] alloc_data = '0;
  logic [TW-1:0] alloc_tag = '0;
  logic          wake_valid = 1'b0;
  logic [TW-1:0] wake_tag = '0;
  logic          iss1_ready = 1'b0;
  logic          iss2_ready = 1'b0;

  logic          alloc_ready;
  logic          iss1_valid;
  logic [DW-1:0] iss1_data;
  logic [IW-1:0] iss1_idx;
  logic          iss2_valid;
  logic [DW-1:0] iss2_data;
  logic [IW-1:0] iss2_idx;
  logic [IW:0]   count;

  int tests = 0;
  int fails = 0;

  bit            m_valid [N];
  bit            m_rdy   [N];
  logic [TW-1:0] m_tag   [N];
  logic [DW-1:0] m_data  [N];

  always #5 clk = ~clk;

  dual_issue_queue dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
`ifdef DUAL_ISSUE_QUEUE_FLUSH_EN
    .i_flush       (flush),
`endif
    .i_alloc_valid (alloc_valid),
    .o_alloc_ready (alloc_ready),
    .i_alloc_data  (alloc_data),
    .i_alloc_tag   (alloc_tag),
    .i_alloc_rdy   (alloc_rdy),
    .i_wake_valid  (wake_valid),
    .i_wake_tag    (wake_tag),
    .o_iss1_valid  (iss1_valid),
    .o_iss1_data   (iss1_data),
    .o_iss1_idx    (iss1_idx),
    .i_iss1_ready  (iss1_ready),
    .o_iss2_valid  (iss2_valid),
    .o_iss2_data   (iss2_data),
    .o_iss2_idx    (iss2_idx),
    .i_iss2_ready  (iss2_ready),
    .o_count       (count)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int skip);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_rdy[i] && i != skip) return i;
    return -1;
  endfunction

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  int  mp1, mp2, mfree;
  bit  mar;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_rdy[i]   = 1'b0;
      end
    end else begin
      mp1   = pick(-1);
      mp2   = (mp1 < 0) ? -1 : pick(mp1);
      mfree = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) mfree = i;
      mar = (mfree >= 0) && !flush;
      if (flush) begin
        for (int i = 0; i < N; i++) begin
          m_valid[i] = 1'b0;
          m_rdy[i]   = 1'b0;
        end
      end else begin
        for (int i = 0; i < N; i++)
          if (wake_valid && m_valid[i] && m_tag[i] == wake_tag)
            m_rdy[i] = 1'b1;
        if (mp1 >= 0 && iss1_ready) begin
          m_valid[mp1] = 1'b0;
          m_rdy[mp1]   = 1'b0;
        end
        if (mp2 >= 0 && iss2_ready) begin
          m_valid[mp2] = 1'b0;
          m_rdy[mp2]   = 1'b0;
        end
        if (alloc_valid && mar) begin
          m_valid[mfree] = 1'b1;
          m_rdy[mfree]   = alloc_rdy
                         || (wake_valid && alloc_tag == wake_tag);
          m_tag[mfree]   = alloc_tag;
          m_data[mfree]  = alloc_data;
        end
      end
    end
  end

  int e1, e2, occ;

  always @(negedge clk) begin
    e1  = pick(-1);
    e2  = (e1 < 0) ? -1 : pick(e1);
    occ = occupancy();
    chk("count", count, occ);
    chk("alloc_ready", alloc_ready, (occ < N && !flush) ? 1 : 0);
    chk("iss1_valid", iss1_valid, (e1 >= 0) ? 1 : 0);
    chk("iss2_valid", iss2_valid, (e2 >= 0) ? 1 : 0);
    if (e1 >= 0) begin
      chk("iss1_idx", iss1_idx, e1);
      chk("iss1_data", iss1_data, m_data[e1]);
    end else begin
      chk("iss1_idx_idle", iss1_idx, 0);
      chk("iss1_data_idle", iss1_data, 0);
    end
    if (e2 >= 0) begin
      chk("iss2_idx", iss2_idx, e2);
      chk("iss2_data", iss2_data, m_data[e2]);
    end else begin
      chk("iss2_idx_idle", iss2_idx, 0);
      chk("iss2_data_idle", iss2_data, 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic alloc(input logic [TW-1:0] t, input logic r,
                       input logic [DW-1:0] d);
    alloc_valid = 1'b1;
    alloc_tag   = t;
    alloc_rdy   = r;
    alloc_data  = d;
    cyc();
    alloc_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_iss1_valid", iss1_valid, 0);
    chk("rst_iss2_valid", iss2_valid, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < N; i++) alloc(TW'(i), 1'b1, DW'(100 + i));
    chk("full_count", count, 12);
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_iss1_idx", iss1_idx, 0);
    chk("full_iss2_idx", iss2_idx, 1);
    chk("full_iss2_data", iss2_data, 101);

    alloc_valid = 1'b1;
    alloc_rdy   = 1'b1;
    alloc_tag   = '0;
    alloc_data  = 32'hAA;
    iss1_ready  = 1'b1;
    cyc();
    chk("blocked_count", count, 11);
    chk("blocked_iss1_idx", iss1_idx, 1);
    iss1_ready = 1'b0;
    cyc();
    alloc_valid = 1'b0;
    chk("refill_count", count, 12);
    chk("refill_iss1_idx", iss1_idx, 0);
    chk("refill_iss1_data", iss1_data, 32'hAA);

    iss1_ready = 1'b1;
    iss2_ready = 1'b1;
    repeat (6) cyc();
    iss1_ready = 1'b0;
    iss2_ready = 1'b0;
    chk("drain_count", count, 0);

    for (int i = 0; i < N; i++) alloc(TW'(10 + i), 1'b0, DW'(200 + i));
    chk("waiting_iss1_valid", iss1_valid, 0);
    wake_valid = 1'b1;
    wake_tag   = 6'd13;
    cyc();
    wake_tag = 6'd17;
    cyc();
    wake_valid = 1'b0;
    chk("pair_iss1_idx", iss1_idx, 3);
    chk("pair_iss2_idx", iss2_idx, 7);
    chk("pair_iss2_data", iss2_data, 207);
    iss1_ready = 1'b1;
    iss2_ready = 1'b1;
    cyc();
    iss1_ready = 1'b0;
    iss2_ready = 1'b0;
    chk("pair_count", count, 10);
    chk("pair_iss1_gone", iss1_valid, 0);
    chk("pair_iss2_gone", iss2_valid, 0);

    alloc(6'd5, 1'b0, 32'h55);
    chk("tag5_not_ready", iss1_valid, 0);
    wake_valid = 1'b1;
    wake_tag   = 6'd5;
    cyc();
    wake_valid = 1'b0;
    chk("tag5_woken_valid", iss1_valid, 1);
    chk("tag5_woken_idx", iss1_idx, 3);
    wake_valid = 1'b1;
    wake_tag   = 6'd5;
    alloc(6'd5, 1'b0, 32'h77);
    wake_valid = 1'b0;
    chk("bypass_iss2_idx", iss2_idx, 7);
    chk("bypass_iss2_data", iss2_data, 32'h77);

    #1 rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_iss1_valid", iss1_valid, 0);
    chk("midrst_iss2_valid", iss2_valid, 0);
    chk("midrst_alloc_ready", alloc_ready, 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 3; i++) alloc(6'd0, 1'b1, DW'(300 + i));
    iss2_ready = 1'b1;
    cyc();
    chk("stall_iss1_idx", iss1_idx, 0);
    chk("stall_iss2_idx", iss2_idx, 2);
    cyc();
    chk("stall2_iss1_idx", iss1_idx, 0);
    chk("stall2_iss2_valid", iss2_valid, 0);
    chk("stall2_count", count, 1);
    iss2_ready = 1'b0;

`ifdef DUAL_ISSUE_QUEUE_FLUSH_EN
    for (int i = 0; i < 5; i++) alloc(6'd0, 1'b1, DW'(400 + i));
    chk("pre_flush_count", count, 6);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    iss1_ready  = 1'b1;
    #1;
    chk("flush_alloc_ready", alloc_ready, 0);
    cyc();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    iss1_ready  = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_iss1_valid", iss1_valid, 0);
    chk("flush_iss2_valid", iss2_valid, 0);
    for (int i = 0; i < 6; i++) alloc(6'd0, 1'b1, DW'(500 + i));
    alloc_valid = 1'b1;
    cyc();
    #1 rst_n = 1'b0;
    #1;
    alloc_valid = 1'b0;
    chk("burst_rst_count", count, 0);
    chk("burst_rst_iss1_valid", iss1_valid, 0);
    chk("burst_rst_iss2_valid", iss2_valid, 0);
    cyc();
    rst_n = 1'b1;
`endif

    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
